// File: rtl/mux_pkg.sv
// Shared constants and helpers for the lane multiplexer: select-width sizing
// and the lane-extract function used by the select decode.
package mux_pkg;

  localparam int MUX_DEF_WIDTH  = 1;
  localparam int MUX_DEF_NUM_IN = 2;

  // Upper bounds on the packed bus and a single lane accepted by lane_extract.
  localparam int MUX_MAX_BITS = 1024;
  localparam int MUX_MAX_W    = 256;

  // ceil(log2(n)), never less than 1 so a 1-bit select always exists.
  function automatic int mux_clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) begin
      w = w + 1;
    end
    return w;
  endfunction

  // Returns lane 'sel' of 'bus' (lane 0 in the LSBs), or zero when out of range.
  // Bits above 'width' in the result belong to higher lanes; callers truncate.
  function automatic logic [MUX_MAX_W-1:0] lane_extract(
    input logic [MUX_MAX_BITS-1:0] bus,
    input int                      width,
    input int                      num_in,
    input int                      sel
  );
    if (sel >= num_in) begin
      return '0;
    end
    return MUX_MAX_W'(bus >> (sel * width));
  endfunction

endpackage

// File: rtl/mux_out_reg.sv
// WIDTH-bit output register with asynchronous active-high clear.
module mux_out_reg #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/mux.sv
// N-input lane multiplexer; out-of-range selects yield zero.
// Define MUX_OUT_REG_EN to add a one-cycle output register on clk/rst.
module mux
  import mux_pkg::*;
#(
  parameter int WIDTH  = MUX_DEF_WIDTH,
  parameter int NUM_IN = MUX_DEF_NUM_IN,
  parameter int SEL_W  = mux_clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN*WIDTH-1:0] in,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        out
);

  logic [WIDTH-1:0] lane;

  always_comb begin
    lane = WIDTH'(lane_extract(MUX_MAX_BITS'(in), WIDTH, NUM_IN, int'(sel)));
  end

`ifdef MUX_OUT_REG_EN
  mux_out_reg #(
    .WIDTH(WIDTH)
  ) u_out_reg (
    .clk(clk),
    .rst(rst),
    .d  (lane),
    .q  (out)
  );
`else
  assign out = lane;

  // clk/rst stay on the port list so both builds share one interface.
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst;
`endif

endmodule

// File: tb/tb_mux.sv
// Scoreboard bench for mux: default 1x2 instance and a 4-bit x 3-lane instance.
// Covers the combinational build and, with MUX_OUT_REG_EN, the registered build.
module tb_mux;

  typedef struct {
    string      tag;
    logic [3:0] exp;
  } sb_item_t;

  sb_item_t sb[$];
  int compared   = 0;
  int mismatched = 0;

  logic        clk    = 1'b0;
  logic        clk_en = 1'b1;
  logic        rst    = 1'b0;
  logic [1:0]  in_a   = '0;
  logic        sel_a  = 1'b0;
  logic        out_a;
  logic [11:0] in_b   = '0;
  logic [1:0]  sel_b  = '0;
  logic [3:0]  out_b;

  mux dut_a (
    .clk(clk),
    .rst(rst),
    .in (in_a),
    .sel(sel_a),
    .out(out_a)
  );

  mux #(
    .WIDTH (4),
    .NUM_IN(3)
  ) dut_b (
    .clk(clk),
    .rst(rst),
    .in (in_b),
    .sel(sel_b),
    .out(out_b)
  );

  always #5 if (clk_en) clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "bench timed out");
  end

  task automatic push_exp(input string tag, input logic [3:0] e);
    sb_item_t it;
    it.tag = tag;
    it.exp = e;
    sb.push_back(it);
  endtask

  task automatic check_pop(input logic [3:0] obs);
    sb_item_t it;
    compared++;
    assert (sb.size() != 0) else begin
      mismatched++;
      $error("FAIL sb_empty: observed output %h with no expectation queued", obs);
      return;
    end
    it = sb.pop_front();
    assert (obs === it.exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", it.tag, obs, it.exp);
    end
  endtask

  // Combinational build settles in-timestep; registered build needs one edge.
  task automatic settle();
`ifdef MUX_OUT_REG_EN
    @(posedge clk);
    #1;
`else
    #10;
`endif
  endtask

  task automatic step_a(input logic [1:0] i, input logic s, input logic e, input string tag);
    in_a  = i;
    sel_a = s;
    push_exp(tag, {3'b000, e});
    settle();
    check_pop({3'b000, out_a});
  endtask

  task automatic step_b(input logic [11:0] i, input logic [1:0] s, input logic [3:0] e, input string tag);
    in_b  = i;
    sel_b = s;
    push_exp(tag, e);
    settle();
    check_pop(out_b);
  endtask

  function automatic logic [3:0] model_b(input logic [11:0] i, input logic [1:0] s);
    case (s)
      2'd0:    return i[3:0];
      2'd1:    return i[7:4];
      2'd2:    return i[11:8];
      default: return 4'h0;
    endcase
  endfunction

  initial begin
`ifdef MUX_OUT_REG_EN
    // Reset behaviour of the output register.
    rst   = 1'b1;
    in_a  = 2'b11;
    sel_a = 1'b1;
    #1;
    push_exp("reg_rst_hold", 4'h0);
    check_pop({3'b000, out_a});
    @(negedge clk);
    rst = 1'b0;
    #1;
    push_exp("reg_rel_before_edge", 4'h0);
    check_pop({3'b000, out_a});
    @(posedge clk);
    #1;
    push_exp("reg_first_edge", 4'h1);
    check_pop({3'b000, out_a});
    @(negedge clk);
    in_a = 2'b01;
    rst  = 1'b1;
    #1;
    push_exp("reg_async_clear", 4'h0);
    check_pop({3'b000, out_a});
    @(posedge clk);
    #1;
    push_exp("reg_rst_stays_low", 4'h0);
    check_pop({3'b000, out_a});
    @(negedge clk);
    in_a = 2'b11;
    rst  = 1'b0;
    #1;
    push_exp("reg_rel2_before_edge", 4'h0);
    check_pop({3'b000, out_a});
    @(posedge clk);
    #1;
    push_exp("reg_rel2_edge", 4'h1);
    check_pop({3'b000, out_a});
`else
    // Combinational build ignores rst and needs no clock.
    rst   = 1'b1;
    in_a  = 2'b11;
    sel_a = 1'b1;
    #10;
    push_exp("comb_rst_ignored", 4'h1);
    check_pop({3'b000, out_a});
    rst = 1'b0;
`endif

    step_a(2'b00, 1'b0, 1'b0, "a_sel0_in00");
    step_a(2'b01, 1'b0, 1'b1, "a_sel0_in01");
    step_a(2'b10, 1'b0, 1'b0, "a_sel0_in10");
    step_a(2'b11, 1'b0, 1'b1, "a_sel0_in11");
    step_a(2'b00, 1'b1, 1'b0, "a_sel1_in00");
    step_a(2'b01, 1'b1, 1'b0, "a_sel1_in01");
    step_a(2'b10, 1'b1, 1'b1, "a_sel1_in10");
    step_a(2'b11, 1'b1, 1'b1, "a_sel1_in11");

    step_b(12'hA5C, 2'd0, 4'hC, "b_sel0");
    step_b(12'hA5C, 2'd1, 4'h5, "b_sel1");
    step_b(12'hA5C, 2'd2, 4'hA, "b_sel2");
    step_b(12'hA5C, 2'd3, 4'h0, "b_sel3_out_of_range");
    step_b(12'hFFF, 2'd3, 4'h0, "b_sel3_all_ones");
    step_b(12'h321, 2'd2, 4'h3, "b_lane_order");

    for (int n = 0; n < 12; n++) begin
      logic [11:0] ri;
      logic [1:0]  rs;
      ri = 12'($urandom);
      rs = 2'($urandom_range(0, 3));
      step_b(ri, rs, model_b(ri, rs), $sformatf("b_rand%0d", n));
    end

`ifndef MUX_OUT_REG_EN
    // Select toggling with the clock stopped.
    clk_en = 1'b0;
    in_a   = 2'b10;
    sel_a  = 1'b0;
    #1;
    push_exp("a_tog_sel0", 4'h0);
    check_pop({3'b000, out_a});
    sel_a = 1'b1;
    #1;
    push_exp("a_tog_sel1", 4'h1);
    check_pop({3'b000, out_a});
    sel_a = 1'b0;
    #1;
    push_exp("a_tog_back0", 4'h0);
    check_pop({3'b000, out_a});
    // Simultaneous change of in and sel.
    in_b  = 12'h7E1;
    sel_b = 2'd1;
    #1;
    push_exp("b_simultaneous", 4'hE);
    check_pop(out_b);
`endif

    compared++;
    assert (sb.size() == 0) else begin
      mismatched++;
      $error("FAIL sb_drain: observed %0d leftover expected 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
